ccw_executor: RTL and testbench
===============================

# ccw_executor

Executes one channel command word (CCW) at a time on top of the parallel channel block; it sits directly upstream of it. Accepts a CCW (device address, command, byte count) from the host side and pulses the channel's start. It streams at most `count` bytes between host AXI-Streams and the channel's data streams and raises the channel's stop once the count is exhausted. When the channel drops active, it reports final status, condition code, residual count and incorrect-length.

## Interface
- `ACTIVE_TIMEOUT`, 64: cycles allowed between `chan_start` and `chan_active` rising before the CCW is abandoned.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `ccw_addr` in 8: device address for the CCW.
- `ccw_command` in 8: command byte for the CCW.
- `ccw_count` in 16: byte count for the CCW.
- `ccw_valid` in 1 / `ccw_ready` out 1: CCW handshake.
- `host_tx_tdata` in 8, `host_tx_tvalid` in 1, `host_tx_tready` out 1: bytes to send.
- `host_rx_tdata` out 8, `host_rx_tvalid` out 1, `host_rx_tready` in 1: bytes received.
- `result_valid` out 1: 1-cycle completion pulse.
- `result_status` out 8: last status byte captured.
- `result_cc` out 2: condition code.
- `result_residual` out 16: untransferred count.
- `result_il` out 1: incorrect length.
- `chan_addr` out 8, `chan_command` out 8: registered and held for the whole CCW.
- `chan_start` out 1: 1-cycle pulse.
- `chan_stop` out 1: level.
- `chan_active` in 1: channel subchannel-active.
- `chan_condition_code` in 2: channel condition code.
- `chan_status_tdata` in 8, `chan_status_tvalid` in 1: status byte stream.
- `chan_send_tdata` out 8, `chan_send_tvalid` out 1, `chan_send_tready` in 1: bytes to the channel.
- `chan_recv_tdata` in 8, `chan_recv_tvalid` in 1, `chan_recv_tready` out 1: bytes from the channel.

## Operation
- States: IDLE, START, WAIT_ACTIVE, RUN, DONE.
- IDLE:
  - `ccw_ready`=1.
  - On `ccw_valid`: latch addr, command and count into `chan_addr`, `chan_command` and `remaining`.
  - Clear `status_reg`=0, `long_flag`=0 and the timer, then go to START.
- START: `chan_start`=1 for exactly this cycle, then go to WAIT_ACTIVE.
- WAIT_ACTIVE:
  - If `chan_active`=1, go to RUN.
  - If the timer reaches `ACTIVE_TIMEOUT`, go to DONE with a forced cc=3.
- RUN:
  - Every `chan_status_tvalid` pulse loads `status_reg`.
  - `chan_stop` = (`remaining`==0), registered and held until DONE.
  - Send path (combinational, gated by state==RUN and `remaining`!=0):
    - `chan_send_tvalid` = `host_tx_tvalid`.
    - `host_tx_tready` = `chan_send_tready`.
    - `chan_send_tdata` = `host_tx_tdata`.
  - Receive path (same gating):
    - `host_rx_tvalid` = `chan_recv_tvalid`.
    - `chan_recv_tready` = `host_rx_tready`.
    - `host_rx_tdata` = `chan_recv_tdata`.
  - Each completed beat on either path decrements `remaining`. Saturating at 0 is unreachable by construction.
  - If `remaining`==0 and (`chan_send_tready` or `chan_recv_tvalid`) is observed: set `long_flag`. The channel then answers the device with command-out because stop is high.
  - `chan_active`==0 goes to DONE.
- DONE (one cycle):
  - `result_valid`=1.
  - `result_status` = `status_reg`.
  - `result_residual` = `remaining`.
  - `result_cc` = 3 if timeout, else `chan_condition_code`.
  - `result_il` = `long_flag` | (`remaining`!=0 & `result_cc`==0).
  - Then go to IDLE.
- Count 0 CCW: stop is asserted from the first RUN cycle, and any data request sets `long_flag`.
- Reset: state IDLE, and all registered outputs return to 0.
  - This covers `chan_start`, `chan_stop`, `result_valid`, `result_*`, `chan_addr` and `chan_command`.
  - All stream valids/readies are 0 because state≠RUN.
  - Reset mid-RUN aborts with no `result_valid` pulse. The channel is reset by the same signal.

## Timing
- `ccw_valid` accept at cycle N.
  - `chan_start` high at N+1.
  - Earliest RUN at N+3, since `chan_active` rises 1 cycle after the channel samples start.
- Stream paths add zero latency. A beat completes when tvalid&tready is high at a clk edge.
- The `remaining` decrement and `chan_stop` update are visible the cycle after the final beat. The channel's send/recv states sample stop no earlier than the next service-in, so no extra byte is ever transferred.
- `chan_status_tvalid` coincident with `chan_active` falling: the status is captured into `result_status`.
- `result_valid` follows the `chan_active` fall by 1 cycle.
- `ccw_ready` returns 1 cycle after `result_valid`.
- `ccw_valid` held through DONE is not accepted until IDLE.

## Test plan
- Write: addr 0x50, cmd 0x01, count 3, host bytes A1 A2 A3; device requests 3 then ends with status 0x0C. Required: channel sends A1 A2 A3, and the result is status 0x0C, cc 0, residual 0, il 0.
- Long read: cmd 0x02, count 2; device offers 3 bytes. Required: host receives exactly 2 bytes, `chan_stop` goes 1 after byte 2, and il=1 with residual 0.
- Short read: count 4; device ends with 0x0C after 1 byte. Required: residual 3, il=1.
- Not operational: device answers select-in. Required: result cc=3, status 0x00, no stream beats.
- Timeout: `chan_active` tied 0. Required: `result_valid` at start+`ACTIVE_TIMEOUT`+1 with cc=3.
- Backpressure and reset: `host_rx_tready` toggled 1-of-3 cycles gives no lost or duplicated bytes. Reset asserted mid-RUN clears all outputs to 0, gives no `result_valid`, and a following CCW executes normally.

Source files
------------

// File: rtl/ccw_executor.sv
// ccw_executor: runs one channel command word on the parallel channel.
// It starts the channel, passes up to `count` bytes between the host streams
// and the channel, raises stop when the count is used up, and reports the
// final status, condition code, residual count and incorrect-length flag.
module ccw_executor #(
  parameter int unsigned ACTIVE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  // CCW from host
  input  logic [7:0]  ccw_addr,
  input  logic [7:0]  ccw_command,
  input  logic [15:0] ccw_count,
  input  logic        ccw_valid,
  output logic        ccw_ready,
  // host data streams
  input  logic [7:0]  host_tx_tdata,
  input  logic        host_tx_tvalid,
  output logic        host_tx_tready,
  output logic [7:0]  host_rx_tdata,
  output logic        host_rx_tvalid,
  input  logic        host_rx_tready,
  // completion report
  output logic        result_valid,
  output logic [7:0]  result_status,
  output logic [1:0]  result_cc,
  output logic [15:0] result_residual,
  output logic        result_il,
  // channel control
  output logic [7:0]  chan_addr,
  output logic [7:0]  chan_command,
  output logic        chan_start,
  output logic        chan_stop,
  input  logic        chan_active,
  input  logic [1:0]  chan_condition_code,
  input  logic [7:0]  chan_status_tdata,
  input  logic        chan_status_tvalid,
  // channel data streams
  output logic [7:0]  chan_send_tdata,
  output logic        chan_send_tvalid,
  input  logic        chan_send_tready,
  input  logic [7:0]  chan_recv_tdata,
  input  logic        chan_recv_tvalid,
  output logic        chan_recv_tready
);

  localparam int unsigned TIMER_W = $clog2(ACTIVE_TIMEOUT + 1);
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_ACTIVE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [COUNT_W-1:0]   remaining_q;
  logic [COUNT_W-1:0]   remaining_d;
  logic [BYTE_W-1:0]    status_q;
  logic [BYTE_W-1:0]    status_d;
  logic                 long_q;
  logic                 long_d;
  logic [TIMER_W-1:0]   timer_q;
  logic [TIMER_W-1:0]   timer_d;
  logic                 accept;
  logic                 timeout_hit;
  logic                 send_beat;
  logic                 recv_beat;
  logic [1:0]           beat_cnt;
  logic [1:0]           cc_d;
  logic                 il_d;

  assign accept      = (state_q == S_IDLE) && ccw_valid;
  assign timeout_hit = (state_q == S_WAIT_ACTIVE) && !chan_active &&
                       (timer_q == TIMER_W'(ACTIVE_TIMEOUT));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        if (ccw_valid) state_d = S_START;
      S_START:       state_d = S_WAIT_ACTIVE;
      S_WAIT_ACTIVE: begin
        if (chan_active)      state_d = S_RUN;
        else if (timeout_hit) state_d = S_DONE;
      end
      S_RUN:         if (!chan_active) state_d = S_DONE;
      S_DONE:        state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // Stream steering, handshakes and next values of the datapath registers
  always_comb begin
    ccw_ready        = 1'b0;
    chan_send_tvalid = 1'b0;
    chan_send_tdata  = '0;
    host_tx_tready   = 1'b0;
    host_rx_tvalid   = 1'b0;
    host_rx_tdata    = '0;
    chan_recv_tready = 1'b0;
    send_beat        = 1'b0;
    recv_beat        = 1'b0;
    beat_cnt         = '0;
    remaining_d      = remaining_q;
    status_d         = status_q;
    long_d           = long_q;
    timer_d          = timer_q;
    case (state_q)
      S_IDLE: begin
        ccw_ready = 1'b1;
        if (ccw_valid) begin
          remaining_d = ccw_count;
          status_d    = '0;
          long_d      = 1'b0;
          timer_d     = '0;
        end
      end
      S_START, S_WAIT_ACTIVE: begin
        timer_d = timer_q + TIMER_W'(1);
      end
      S_RUN: begin
        if (remaining_q != '0) begin
          chan_send_tvalid = host_tx_tvalid;
          chan_send_tdata  = host_tx_tdata;
          host_tx_tready   = chan_send_tready;
          host_rx_tvalid   = chan_recv_tvalid;
          host_rx_tdata    = chan_recv_tdata;
          chan_recv_tready = host_rx_tready;
          send_beat        = host_tx_tvalid && chan_send_tready;
          recv_beat        = chan_recv_tvalid && host_rx_tready;
        end else if (chan_send_tready || chan_recv_tvalid) begin
          // device still wants data after the count ran out
          long_d = 1'b1;
        end
        beat_cnt = {1'b0, send_beat} + {1'b0, recv_beat};
        if (remaining_q > COUNT_W'(beat_cnt)) begin
          remaining_d = remaining_q - COUNT_W'(beat_cnt);
        end else begin
          remaining_d = '0;
        end
        if (chan_status_tvalid) status_d = chan_status_tdata;
      end
      default: ;
    endcase
    cc_d = timeout_hit ? 2'd3 : chan_condition_code;
    il_d = long_d | ((remaining_d != '0) && (cc_d == 2'd0));
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_q     <= '0;
      status_q        <= '0;
      long_q          <= 1'b0;
      timer_q         <= '0;
      chan_addr       <= '0;
      chan_command    <= '0;
      chan_start      <= 1'b0;
      chan_stop       <= 1'b0;
      result_valid    <= 1'b0;
      result_status   <= '0;
      result_cc       <= '0;
      result_residual <= '0;
      result_il       <= 1'b0;
    end else begin
      remaining_q  <= remaining_d;
      status_q     <= status_d;
      long_q       <= long_d;
      timer_q      <= timer_d;
      chan_start   <= (state_d == S_START);
      chan_stop    <= (state_d == S_RUN) && (remaining_d == '0);
      result_valid <= (state_d == S_DONE);
      if (accept) begin
        chan_addr    <= ccw_addr;
        chan_command <= ccw_command;
      end
      if (state_d == S_DONE) begin
        result_status   <= status_d;
        result_cc       <= cc_d;
        result_residual <= remaining_d;
        result_il       <= il_d;
      end
    end
  end

endmodule

// File: tb/tb_ccw_executor.sv
// Directed bench for ccw_executor: write, long/short read, not-operational,
// timeout, receive backpressure and reset in the middle of a CCW.
module tb_ccw_executor;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ccw_addr;
  logic [7:0]  ccw_command;
  logic [15:0] ccw_count;
  logic        ccw_valid;
  logic        ccw_ready;
  logic [7:0]  host_tx_tdata;
  logic        host_tx_tvalid;
  logic        host_tx_tready;
  logic [7:0]  host_rx_tdata;
  logic        host_rx_tvalid;
  logic        host_rx_tready;
  logic        result_valid;
  logic [7:0]  result_status;
  logic [1:0]  result_cc;
  logic [15:0] result_residual;
  logic        result_il;
  logic [7:0]  chan_addr;
  logic [7:0]  chan_command;
  logic        chan_start;
  logic        chan_stop;
  logic        chan_active;
  logic [1:0]  chan_condition_code;
  logic [7:0]  chan_status_tdata;
  logic        chan_status_tvalid;
  logic [7:0]  chan_send_tdata;
  logic        chan_send_tvalid;
  logic        chan_send_tready;
  logic [7:0]  chan_recv_tdata;
  logic        chan_recv_tvalid;
  logic        chan_recv_tready;

  int errors = 0;
  int checks = 0;

  ccw_executor #(.ACTIVE_TIMEOUT(64)) dut (
    .clk                 (clk),
    .reset               (reset),
    .ccw_addr            (ccw_addr),
    .ccw_command         (ccw_command),
    .ccw_count           (ccw_count),
    .ccw_valid           (ccw_valid),
    .ccw_ready           (ccw_ready),
    .host_tx_tdata       (host_tx_tdata),
    .host_tx_tvalid      (host_tx_tvalid),
    .host_tx_tready      (host_tx_tready),
    .host_rx_tdata       (host_rx_tdata),
    .host_rx_tvalid      (host_rx_tvalid),
    .host_rx_tready      (host_rx_tready),
    .result_valid        (result_valid),
    .result_status       (result_status),
    .result_cc           (result_cc),
    .result_residual     (result_residual),
    .result_il           (result_il),
    .chan_addr           (chan_addr),
    .chan_command        (chan_command),
    .chan_start          (chan_start),
    .chan_stop           (chan_stop),
    .chan_active         (chan_active),
    .chan_condition_code (chan_condition_code),
    .chan_status_tdata   (chan_status_tdata),
    .chan_status_tvalid  (chan_status_tvalid),
    .chan_send_tdata     (chan_send_tdata),
    .chan_send_tvalid    (chan_send_tvalid),
    .chan_send_tready    (chan_send_tready),
    .chan_recv_tdata     (chan_recv_tdata),
    .chan_recv_tvalid    (chan_recv_tvalid),
    .chan_recv_tready    (chan_recv_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Accept a CCW and walk through START/WAIT_ACTIVE; leaves the bench in the
  // first RUN cycle when go_active is set.
  task automatic start_ccw(input logic [7:0] a, input logic [7:0] c,
                           input logic [15:0] n, input logic go_active);
    ccw_addr = a; ccw_command = c; ccw_count = n; ccw_valid = 1'b1;
    #1;
    chk("ccw_ready_idle", 32'(ccw_ready), 32'd1);
    cyc;
    ccw_valid = 1'b0;
    chk("chan_start_pulse", 32'(chan_start), 32'd1);
    chk("chan_addr", 32'(chan_addr), 32'(a));
    chk("chan_command", 32'(chan_command), 32'(c));
    cyc;
    chk("chan_start_drop", 32'(chan_start), 32'd0);
    if (go_active) chan_active = 1'b1;
    cyc;
  endtask

  // Channel drops active; check the one-cycle result report.
  task automatic end_ccw(input logic st_v, input logic [7:0] st, input logic [1:0] cc,
                         input logic [7:0] e_st, input logic [1:0] e_cc,
                         input logic [15:0] e_res, input logic e_il);
    chan_active = 1'b0;
    chan_status_tvalid = st_v; chan_status_tdata = st; chan_condition_code = cc;
    cyc;
    chan_status_tvalid = 1'b0; chan_condition_code = 2'd0;
    chk("result_valid", 32'(result_valid), 32'd1);
    chk("result_status", 32'(result_status), 32'(e_st));
    chk("result_cc", 32'(result_cc), 32'(e_cc));
    chk("result_residual", 32'(result_residual), 32'(e_res));
    chk("result_il", 32'(result_il), 32'(e_il));
    chk("ccw_ready_done", 32'(ccw_ready), 32'd0);
    cyc;
    chk("result_valid_drop", 32'(result_valid), 32'd0);
    chk("ccw_ready_back", 32'(ccw_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] rx [6];
    int idx;
    int k;
    int n;

    reset = 1'b1;
    ccw_addr = '0; ccw_command = '0; ccw_count = '0; ccw_valid = 1'b0;
    host_tx_tdata = '0; host_tx_tvalid = 1'b0; host_rx_tready = 1'b0;
    chan_active = 1'b0; chan_condition_code = '0;
    chan_status_tdata = '0; chan_status_tvalid = 1'b0;
    chan_send_tready = 1'b0; chan_recv_tdata = '0; chan_recv_tvalid = 1'b0;

    // reset state
    cyc; cyc;
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_chan_start", 32'(chan_start), 32'd0);
    chk("rst_chan_stop", 32'(chan_stop), 32'd0);
    chk("rst_chan_addr", 32'(chan_addr), 32'd0);
    chk("rst_host_rx_tvalid", 32'(host_rx_tvalid), 32'd0);
    chk("rst_ccw_ready", 32'(ccw_ready), 32'd1);
    reset = 1'b0;
    cyc;

    // write: 3 bytes A1 A2 A3, status 0C
    start_ccw(8'h50, 8'h01, 16'd3, 1'b1);
    chk("wr_stop_low", 32'(chan_stop), 32'd0);
    chan_send_tready = 1'b1; host_tx_tvalid = 1'b1;
    host_tx_tdata = 8'hA1; #1;
    chk("wr_b1_valid", 32'(chan_send_tvalid), 32'd1);
    chk("wr_b1_data", 32'(chan_send_tdata), 32'hA1);
    chk("wr_b1_ready", 32'(host_tx_tready), 32'd1);
    cyc;
    host_tx_tdata = 8'hA2; #1;
    chk("wr_b2_data", 32'(chan_send_tdata), 32'hA2);
    cyc;
    host_tx_tdata = 8'hA3; #1;
    chk("wr_b3_data", 32'(chan_send_tdata), 32'hA3);
    cyc;
    chan_send_tready = 1'b0; host_tx_tdata = 8'hA4; #1;
    chk("wr_no_4th_valid", 32'(chan_send_tvalid), 32'd0);
    chk("wr_stop_high", 32'(chan_stop), 32'd1);
    cyc;
    host_tx_tvalid = 1'b0;
    end_ccw(1'b1, 8'h0C, 2'd0, 8'h0C, 2'd0, 16'd0, 1'b0);

    // long read: count 2, device offers 3
    start_ccw(8'h50, 8'h02, 16'd2, 1'b1);
    host_rx_tready = 1'b1; chan_recv_tvalid = 1'b1;
    chan_recv_tdata = 8'hB1; #1;
    chk("lr_b1_valid", 32'(host_rx_tvalid), 32'd1);
    chk("lr_b1_data", 32'(host_rx_tdata), 32'hB1);
    chk("lr_b1_ready", 32'(chan_recv_tready), 32'd1);
    cyc;
    chan_recv_tdata = 8'hB2; #1;
    chk("lr_b2_data", 32'(host_rx_tdata), 32'hB2);
    chk("lr_stop_before", 32'(chan_stop), 32'd0);
    cyc;
    chan_recv_tdata = 8'hB3; #1;
    chk("lr_stop_after", 32'(chan_stop), 32'd1);
    chk("lr_b3_blocked", 32'(host_rx_tvalid), 32'd0);
    chk("lr_b3_no_ready", 32'(chan_recv_tready), 32'd0);
    cyc;
    chan_recv_tvalid = 1'b0; host_rx_tready = 1'b0;
    end_ccw(1'b1, 8'h0C, 2'd0, 8'h0C, 2'd0, 16'd0, 1'b1);

    // backpressure: count 6, host ready one cycle in three
    start_ccw(8'h51, 8'h02, 16'd6, 1'b1);
    idx = 0; k = 0;
    while (idx < 6 && k < 100) begin
      chan_recv_tvalid = 1'b1;
      chan_recv_tdata  = 8'(208 + idx);
      host_rx_tready   = (k % 3 == 0);
      #1;
      if (host_rx_tvalid && host_rx_tready) begin
        rx[idx] = host_rx_tdata;
        idx++;
      end
      cyc;
      k++;
    end
    chan_recv_tvalid = 1'b0; host_rx_tready = 1'b0;
    chk("bp_beats", 32'(idx), 32'd6);
    chk("bp_cycles", 32'(k), 32'd16);
    for (int j = 0; j < 6; j++) chk("bp_byte", 32'(rx[j]), 32'(8'hD0 + 8'(j)));
    chk("bp_stop", 32'(chan_stop), 32'd1);
    end_ccw(1'b1, 8'h0C, 2'd0, 8'h0C, 2'd0, 16'd0, 1'b0);

    // timeout: channel never goes active
    start_ccw(8'h52, 8'h01, 16'd7, 1'b0);
    n = 2;
    while (!result_valid && n < 200) begin
      cyc;
      n++;
    end
    chk("to_latency", 32'(n), 32'd65);
    chk("to_cc", 32'(result_cc), 32'd3);
    chk("to_residual", 32'(result_residual), 32'd7);
    chk("to_il", 32'(result_il), 32'd0);
    chk("to_status", 32'(result_status), 32'd0);
    cyc;
    chk("to_ccw_ready", 32'(ccw_ready), 32'd1);

    // not operational: active briefly, ends with cc 3, no data
    start_ccw(8'h60, 8'h01, 16'd5, 1'b1);
    end_ccw(1'b0, 8'h00, 2'd3, 8'h00, 2'd3, 16'd5, 1'b0);

    // short read: count 4, one byte then status
    start_ccw(8'h61, 8'h02, 16'd4, 1'b1);
    host_rx_tready = 1'b1; chan_recv_tvalid = 1'b1; chan_recv_tdata = 8'hC1; #1;
    chk("sr_b1_data", 32'(host_rx_tdata), 32'hC1);
    cyc;
    chan_recv_tvalid = 1'b0; host_rx_tready = 1'b0;
    end_ccw(1'b1, 8'h0C, 2'd0, 8'h0C, 2'd0, 16'd3, 1'b1);

    // reset in the middle of RUN
    start_ccw(8'h70, 8'h01, 16'd1, 1'b1);
    chan_send_tready = 1'b1; host_tx_tvalid = 1'b1; host_tx_tdata = 8'hE1; #1;
    chk("rm_b1_data", 32'(chan_send_tdata), 32'hE1);
    cyc;
    chan_send_tready = 1'b0; host_tx_tdata = 8'hE2; #1;
    chk("rm_stop_high", 32'(chan_stop), 32'd1);
    reset = 1'b1;
    cyc;
    chan_active = 1'b0; chan_send_tready = 1'b1; #1;
    chk("rm_chan_stop", 32'(chan_stop), 32'd0);
    chk("rm_chan_start", 32'(chan_start), 32'd0);
    chk("rm_result_valid", 32'(result_valid), 32'd0);
    chk("rm_result_status", 32'(result_status), 32'd0);
    chk("rm_result_residual", 32'(result_residual), 32'd0);
    chk("rm_result_il", 32'(result_il), 32'd0);
    chk("rm_chan_addr", 32'(chan_addr), 32'd0);
    chk("rm_chan_command", 32'(chan_command), 32'd0);
    chk("rm_send_tvalid", 32'(chan_send_tvalid), 32'd0);
    chk("rm_tx_tready", 32'(host_tx_tready), 32'd0);
    reset = 1'b0; host_tx_tvalid = 1'b0; chan_send_tready = 1'b0;
    cyc;
    chk("rm_no_result", 32'(result_valid), 32'd0);
    cyc;
    chk("rm_no_result2", 32'(result_valid), 32'd0);

    // following CCW runs normally
    start_ccw(8'h71, 8'h01, 16'd2, 1'b1);
    chan_send_tready = 1'b1; host_tx_tvalid = 1'b1; host_tx_tdata = 8'hE5; #1;
    chk("fw_b1_data", 32'(chan_send_tdata), 32'hE5);
    cyc;
    host_tx_tdata = 8'hE6; #1;
    chk("fw_b2_data", 32'(chan_send_tdata), 32'hE6);
    cyc;
    host_tx_tvalid = 1'b0; chan_send_tready = 1'b0;
    end_ccw(1'b1, 8'h0C, 2'd0, 8'h0C, 2'd0, 16'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
